// File: rtl/rsa_pkg.sv
// Shared encodings for the modexp arbiter: FSM states, owner ids, default sizes.
package rsa_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_ENC = 1'b0,
    OWN_DEC = 1'b1
  } owner_t;

endpackage

// File: rtl/rsa_rr_pick2.sv
// Two-way round-robin select, purely combinational (zero latency).
// On a tie the requester not served last wins; it applies no backpressure itself.
module rsa_rr_pick2
  import rsa_pkg::*;
(
  input  logic req_enc,
  input  logic req_dec,
  input  logic last,
  output logic gnt_vld,
  output logic winner
);

  assign gnt_vld = req_enc | req_dec;
  assign winner  = (req_enc && req_dec) ? (last == OWN_ENC) : req_dec;

endmodule

// File: rtl/rsa_modexp_arbiter.sv
// Shares one modexp engine between encrypt and decrypt requesters; ack in the grant cycle,
// eng_start 1 cycle later, done 1 cycle after eng_finish. Requests seen while busy wait in IDLE.
module rsa_modexp_arbiter
  import rsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enc_req,
  input  logic [2*WIDTH-1:0]   enc_base,
  input  logic [2*WIDTH-1:0]   enc_exp,
  input  logic [2*WIDTH-1:0]   enc_mod,
  output logic                 enc_ack,
  output logic                 enc_done,
  output logic [2*WIDTH-1:0]   enc_result,
  input  logic                 dec_req,
  input  logic [2*WIDTH-1:0]   dec_base,
  input  logic [2*WIDTH-1:0]   dec_exp,
  input  logic [2*WIDTH-1:0]   dec_mod,
  output logic                 dec_ack,
  output logic                 dec_done,
  output logic [2*WIDTH-1:0]   dec_result,
  output logic                 eng_start,
  output logic [2*WIDTH-1:0]   eng_base,
  output logic [2*WIDTH-1:0]   eng_exp,
  output logic [2*WIDTH-1:0]   eng_mod,
  input  logic                 eng_finish,
  input  logic [2*WIDTH-1:0]   eng_result,
  output logic                 busy,
  output logic                 owner,
  output logic [CNT_W-1:0]     last_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             rr_last;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             gnt_vld;
  logic             winner;
  logic             grant;

  rsa_rr_pick2 u_pick (
    .req_enc (enc_req),
    .req_dec (dec_req),
    .last    (rr_last),
    .gnt_vld (gnt_vld),
    .winner  (winner)
  );

  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_ONE;

  // Ack is the grant itself; gated by rst_n so nothing is acked while held in reset.
  assign grant   = rst_n && (state == ST_IDLE) && gnt_vld;
  assign enc_ack = grant && !winner;
  assign dec_ack = grant && winner;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_last     <= OWN_DEC;
      owner       <= OWN_ENC;
      cnt         <= '0;
      last_cycles <= '0;
      eng_start   <= 1'b0;
      eng_base    <= '0;
      eng_exp     <= '0;
      eng_mod     <= '0;
      enc_done    <= 1'b0;
      dec_done    <= 1'b0;
      enc_result  <= '0;
      dec_result  <= '0;
    end else begin
      eng_start <= 1'b0;
      enc_done  <= 1'b0;
      dec_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            owner     <= winner;
            eng_base  <= winner ? dec_base : enc_base;
            eng_exp   <= winner ? dec_exp  : enc_exp;
            eng_mod   <= winner ? dec_mod  : enc_mod;
            eng_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_finish) begin
            if (owner) begin
              dec_result <= eng_result;
              dec_done   <= 1'b1;
            end else begin
              enc_result <= eng_result;
              enc_done   <= 1'b1;
            end
            last_cycles <= cnt_inc;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_RESP: begin
          rr_last <= owner;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
